// File: rtl/decode_stage.sv
// RV32/RV64 integer decode stage: one registered slot with a valid/ready handshake
// on both sides, optional M-extension decode and a saturating illegal-instruction counter.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int M_EXT = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             illegal,
  output logic [3:0]       alu_ctrl,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc_out,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULH  = 4'd11,
    ALU_DIV   = 4'd12,
    ALU_REM   = 4'd13,
    ALU_PASSB = 4'd14,
    ALU_ILL   = 4'd15
  } alu_op_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Shared funct3 map for register and immediate ops; 'alt' picks SUB/SRA.
  function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t muldiv_op(input logic [2:0] f3);
    case (f3)
      3'b000:                 return ALU_MUL;
      3'b001, 3'b010, 3'b011: return ALU_MULH;
      3'b100, 3'b101:         return ALU_DIV;
      default:                return ALU_REM;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [5:0]  shamt;
  logic        shift_ok;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // RV64 shifts borrow inst[25] for the sixth shamt bit, so only inst[31:26] must be clean.
  always_comb begin
    shamt    = '0;
    shift_ok = 1'b0;
    if (XLEN == 64) begin
      shamt    = inst[25:20];
      shift_ok = (inst[31:26] == 6'b000000) ||
                 ((funct3 == 3'b101) && (inst[31:26] == 6'b010000));
    end else begin
      shamt    = {1'b0, inst[24:20]};
      shift_ok = (funct7 == F7_BASE) || ((funct3 == 3'b101) && (funct7 == F7_ALT));
    end
  end

  alu_op_t         alu_d;
  logic [XLEN-1:0] imm_d;
  logic            reg_write_d, mem_read_d, mem_write_d, alu_src_d, illegal_d;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    alu_d       = ALU_ADD;
    imm_d       = '0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_src_d   = 1'b0;
    illegal_d   = 1'b0;

    case (opcode)
      OP_LUI: begin
        reg_write_d = 1'b1;
        imm_d       = sext(imm_u);
        alu_d       = ALU_PASSB;
      end
      OP_AUIPC: begin
        reg_write_d = 1'b1;
        imm_d       = sext(imm_u);
      end
      OP_JAL: begin
        reg_write_d = 1'b1;
        imm_d       = sext(imm_j);
      end
      OP_JALR: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = sext(imm_i);
      end
      OP_BRANCH: begin
        imm_d = sext(imm_b);
        alu_d = ALU_SUB;
      end
      OP_LOAD: begin
        reg_write_d = 1'b1;
        mem_read_d  = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = sext(imm_i);
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = sext(imm_s);
      end
      OP_IMM: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_d       = base_op(funct3, (funct3 == 3'b101) && inst[30]);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_d     = XLEN'(shamt);
          illegal_d = !shift_ok;
        end else begin
          imm_d = sext(imm_i);
        end
      end
      OP_REG: begin
        reg_write_d = 1'b1;
        case (funct7)
          F7_BASE: alu_d = base_op(funct3, 1'b0);
          F7_ALT: begin
            alu_d     = base_op(funct3, 1'b1);
            illegal_d = !(funct3 == 3'b000 || funct3 == 3'b101);
          end
          F7_MULDIV: begin
            alu_d     = muldiv_op(funct3);
            illegal_d = (M_EXT == 0);
          end
          default: illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase

    if (illegal_d) begin
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      alu_d       = ALU_ILL;
    end
  end

  logic accept;

  // Flush wins over an incoming word so nothing slips in behind a discard.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      rd          <= '0;
      rs1         <= '0;
      rs2         <= '0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      alu_src     <= 1'b0;
      illegal     <= 1'b0;
      alu_ctrl    <= '0;
      imm         <= '0;
      pc_out      <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rd        <= inst[11:7];
      rs1       <= inst[19:15];
      rs2       <= inst[24:20];
      reg_write <= reg_write_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      alu_src   <= alu_src_d;
      illegal   <= illegal_d;
      alu_ctrl  <= alu_d;
      imm       <= imm_d;
      pc_out    <= pc_in;
      if (illegal_d && (illegal_cnt != {CNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: a wide RV64 instance without M (2-bit counter) and a narrow RV32
// instance with M (8-bit counter) share one stimulus stream.
module tb_decode_stage;

  logic        clk, rst, in_valid, flush, out_ready;
  logic [31:0] inst;
  logic [63:0] pc_in;

  logic        in_ready_w, out_valid_w, reg_write_w, mem_read_w, mem_write_w, alu_src_w, illegal_w;
  logic [4:0]  rd_w, rs1_w, rs2_w;
  logic [3:0]  alu_ctrl_w;
  logic [63:0] imm_w, pc_out_w;
  logic [1:0]  cnt_w;

  logic        in_ready_n, out_valid_n, reg_write_n, mem_read_n, mem_write_n, alu_src_n, illegal_n;
  logic [4:0]  rd_n, rs1_n, rs2_n;
  logic [3:0]  alu_ctrl_n;
  logic [31:0] imm_n, pc_out_n;
  logic [7:0]  cnt_n;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(64), .M_EXT(0), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .inst(inst),
    .pc_in(pc_in), .flush(flush), .out_valid(out_valid_w), .out_ready(out_ready),
    .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w), .reg_write(reg_write_w), .mem_read(mem_read_w),
    .mem_write(mem_write_w), .alu_src(alu_src_w), .illegal(illegal_w), .alu_ctrl(alu_ctrl_w),
    .imm(imm_w), .pc_out(pc_out_w), .illegal_cnt(cnt_w)
  );

  decode_stage #(.XLEN(32), .M_EXT(1), .CNT_W(8)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .inst(inst),
    .pc_in(pc_in[31:0]), .flush(flush), .out_valid(out_valid_n), .out_ready(out_ready),
    .rd(rd_n), .rs1(rs1_n), .rs2(rs2_n), .reg_write(reg_write_n), .mem_read(mem_read_n),
    .mem_write(mem_write_n), .alu_src(alu_src_n), .illegal(illegal_n), .alu_ctrl(alu_ctrl_n),
    .imm(imm_n), .pc_out(pc_out_n), .illegal_cnt(cnt_n)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({out_valid_w, out_valid_n, cnt_w, cnt_n, rd_w, rs1_n, rs2_n, alu_ctrl_w, alu_ctrl_n,
         imm_w, imm_n, pc_out_w, pc_out_n, reg_write_n, mem_read_w, mem_write_n, alu_src_w,
         illegal_n} !== '0) begin
      errors++;
      $display("FAIL reset_state ov_w=%b ov_n=%b cnt_w=%0d cnt_n=%0d imm_w=%h alu_n=%0d expected all zero",
               out_valid_w, out_valid_n, cnt_w, cnt_n, imm_w, alu_ctrl_n);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready_w, in_ready_n} !== 2'b11) begin
      errors++;
      $display("FAIL reset_in_ready got %b%b expected 11", in_ready_w, in_ready_n);
    end
  endtask

  task automatic test_addi;
    in_valid = 1'b1; inst = 32'h0050_0093; pc_in = 64'h100;
    tick;
    in_valid = 1'b0;
    checks++;
    if ({out_valid_n, rd_n, rs1_n, imm_n, alu_ctrl_n, alu_src_n, reg_write_n, illegal_n, pc_out_n}
        !== {1'b1, 5'd1, 5'd0, 32'd5, 4'd0, 1'b1, 1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL addi_narrow got ov=%b rd=%0d rs1=%0d imm=%h alu=%0d src=%b rw=%b ill=%b pc=%h expected 1 1 0 5 0 1 1 0 100",
               out_valid_n, rd_n, rs1_n, imm_n, alu_ctrl_n, alu_src_n, reg_write_n, illegal_n, pc_out_n);
    end
    checks++;
    if ({out_valid_w, imm_w, alu_ctrl_w, pc_out_w} !== {1'b1, 64'd5, 4'd0, 64'h100}) begin
      errors++;
      $display("FAIL addi_wide got ov=%b imm=%h alu=%0d pc=%h expected 1 5 0 100",
               out_valid_w, imm_w, alu_ctrl_w, pc_out_w);
    end
    tick;
    checks++;
    if ({out_valid_w, out_valid_n} !== 2'b00) begin
      errors++;
      $display("FAIL drain_clears_valid got %b%b expected 00", out_valid_w, out_valid_n);
    end
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1; inst = 32'h4020_81B3; pc_in = 64'h300;
    tick;
    checks++;
    if ({out_valid_w, rd_w, rs1_w, rs2_w, alu_ctrl_w, alu_src_w, imm_w, illegal_w}
        !== {1'b1, 5'd3, 5'd1, 5'd2, 4'd1, 1'b0, 64'd0, 1'b0}) begin
      errors++;
      $display("FAIL sub_wide got ov=%b rd=%0d rs1=%0d rs2=%0d alu=%0d src=%b imm=%h ill=%b expected 1 3 1 2 1 0 0 0",
               out_valid_w, rd_w, rs1_w, rs2_w, alu_ctrl_w, alu_src_w, imm_w, illegal_w);
    end
    inst = 32'hFFF0_0093; pc_in = 64'h304;
    tick;
    in_valid = 1'b0;
    checks++;
    if ({out_valid_w, imm_w, pc_out_w, imm_n, pc_out_n}
        !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h304, 32'hFFFF_FFFF, 32'h304}) begin
      errors++;
      $display("FAIL neg_imm_b2b got ov=%b imm_w=%h pc_w=%h imm_n=%h pc_n=%h expected 1 all-ones 304 all-ones 304",
               out_valid_w, imm_w, pc_out_w, imm_n, pc_out_n);
    end
    tick;
  endtask

  task automatic test_mext;
    logic [31:0] words [4]   = '{32'h0220_81B3, 32'h0220_91B3, 32'h0220_C1B3, 32'h0220_E1B3};
    logic [3:0]  alu_exp [4] = '{4'd10, 4'd11, 4'd12, 4'd13};
    logic [1:0]  cnt_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst = words[i];
      tick;
      checks++;
      if ({illegal_w, reg_write_w, alu_ctrl_w, cnt_w} !== {1'b1, 1'b0, 4'd15, cnt_exp[i]}) begin
        errors++;
        $display("FAIL mext_off_%0d got ill=%b rw=%b alu=%0d cnt=%0d expected 1 0 15 %0d",
                 i, illegal_w, reg_write_w, alu_ctrl_w, cnt_w, cnt_exp[i]);
      end
      checks++;
      if ({illegal_n, reg_write_n, alu_ctrl_n, rd_n, cnt_n} !== {1'b0, 1'b1, alu_exp[i], 5'd3, 8'd0}) begin
        errors++;
        $display("FAIL mext_on_%0d got ill=%b rw=%b alu=%0d rd=%0d cnt=%0d expected 0 1 %0d 3 0",
                 i, illegal_n, reg_write_n, alu_ctrl_n, rd_n, cnt_n, alu_exp[i]);
      end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_imm_formats;
    in_valid = 1'b1; inst = 32'h0210_9093;
    tick;
    checks++;
    if ({illegal_w, alu_ctrl_w, imm_w, alu_src_w} !== {1'b0, 4'd2, 64'd33, 1'b1}) begin
      errors++;
      $display("FAIL slli33_wide got ill=%b alu=%0d imm=%h src=%b expected 0 2 21 1",
               illegal_w, alu_ctrl_w, imm_w, alu_src_w);
    end
    checks++;
    if ({illegal_n, alu_ctrl_n, reg_write_n, cnt_n} !== {1'b1, 4'd15, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL slli33_narrow got ill=%b alu=%0d rw=%b cnt=%0d expected 1 15 0 1",
               illegal_n, alu_ctrl_n, reg_write_n, cnt_n);
    end
    inst = 32'h4030_D093;
    tick;
    checks++;
    if ({illegal_w, alu_ctrl_w, imm_w, illegal_n, alu_ctrl_n, imm_n}
        !== {1'b0, 4'd7, 64'd3, 1'b0, 4'd7, 32'd3}) begin
      errors++;
      $display("FAIL srai got ill_w=%b alu_w=%0d imm_w=%h ill_n=%b alu_n=%0d imm_n=%h expected 0 7 3 0 7 3",
               illegal_w, alu_ctrl_w, imm_w, illegal_n, alu_ctrl_n, imm_n);
    end
    inst = 32'h1234_5037;
    tick;
    checks++;
    if ({imm_n, alu_ctrl_n, reg_write_n, alu_src_n, imm_w}
        !== {32'h1234_5000, 4'd14, 1'b1, 1'b0, 64'h1234_5000}) begin
      errors++;
      $display("FAIL lui got imm_n=%h alu=%0d rw=%b src=%b imm_w=%h expected 12345000 14 1 0 12345000",
               imm_n, alu_ctrl_n, reg_write_n, alu_src_n, imm_w);
    end
    inst = 32'hFE20_AE23;
    tick;
    checks++;
    if ({imm_w, mem_write_w, mem_read_w, reg_write_w, alu_src_w, alu_ctrl_w, rs2_w}
        !== {64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 5'd2}) begin
      errors++;
      $display("FAIL store got imm=%h mw=%b mr=%b rw=%b src=%b alu=%0d rs2=%0d expected fffffffffffffffc 1 0 0 1 0 2",
               imm_w, mem_write_w, mem_read_w, reg_write_w, alu_src_w, alu_ctrl_w, rs2_w);
    end
    inst = 32'hFE20_8CE3;
    tick;
    checks++;
    if ({imm_n, alu_ctrl_n, reg_write_n, mem_write_n} !== {32'hFFFF_FFF8, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL branch got imm=%h alu=%0d rw=%b mw=%b expected fffffff8 1 0 0",
               imm_n, alu_ctrl_n, reg_write_n, mem_write_n);
    end
    inst = 32'h0080_00EF;
    tick;
    in_valid = 1'b0;
    checks++;
    if ({imm_w, alu_ctrl_w, reg_write_w, alu_src_w, rd_w} !== {64'd8, 4'd0, 1'b1, 1'b0, 5'd1}) begin
      errors++;
      $display("FAIL jal got imm=%h alu=%0d rw=%b src=%b rd=%0d expected 8 0 1 0 1",
               imm_w, alu_ctrl_w, reg_write_w, alu_src_w, rd_w);
    end
    tick;
  endtask

  task automatic test_backpressure;
    in_valid = 1'b1; inst = 32'h0050_0093; pc_in = 64'h200;
    tick;
    inst = 32'h4020_81B3; pc_in = 64'h204; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid_w, in_ready_w, in_ready_n, rd_n, pc_out_n, pc_out_w, alu_ctrl_w}
          !== {1'b1, 1'b0, 1'b0, 5'd1, 32'h200, 64'h200, 4'd0}) begin
        errors++;
        $display("FAIL stall_%0d got ov=%b rdy=%b%b rd=%0d pc_n=%h pc_w=%h alu=%0d expected 1 00 1 200 200 0",
                 i, out_valid_w, in_ready_w, in_ready_n, rd_n, pc_out_n, pc_out_w, alu_ctrl_w);
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready_w, in_ready_n} !== 2'b11) begin
      errors++;
      $display("FAIL release_ready got %b%b expected 11", in_ready_w, in_ready_n);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if ({out_valid_n, rd_n, pc_out_n, alu_ctrl_n} !== {1'b1, 5'd3, 32'h204, 4'd1}) begin
      errors++;
      $display("FAIL release_next got ov=%b rd=%0d pc=%h alu=%0d expected 1 3 204 1",
               out_valid_n, rd_n, pc_out_n, alu_ctrl_n);
    end
    tick;
    checks++;
    if ({out_valid_w, out_valid_n} !== 2'b00) begin
      errors++;
      $display("FAIL no_duplicate got %b%b expected 00", out_valid_w, out_valid_n);
    end
  endtask

  task automatic test_flush;
    in_valid = 1'b1; inst = 32'h0050_0093; pc_in = 64'h400;
    tick;
    inst = 32'h0000_007F; pc_in = 64'h404; flush = 1'b1; out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid_w, in_ready_w, in_ready_n} !== 3'b100) begin
      errors++;
      $display("FAIL flush_blocks got ov=%b rdy=%b%b expected 1 00", out_valid_w, in_ready_w, in_ready_n);
    end
    tick;
    checks++;
    if ({out_valid_w, out_valid_n} !== 2'b00) begin
      errors++;
      $display("FAIL flush_clears got %b%b expected 00", out_valid_w, out_valid_n);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick;
    checks++;
    if ({out_valid_n, cnt_n, cnt_w, pc_out_n} !== {1'b0, 8'd1, 2'd3, 32'h400}) begin
      errors++;
      $display("FAIL flush_not_accepted got ov=%b cnt_n=%0d cnt_w=%0d pc=%h expected 0 1 3 400",
               out_valid_n, cnt_n, cnt_w, pc_out_n);
    end
  endtask

  task automatic test_async_reset;
    in_valid = 1'b1; inst = 32'h0050_0093; pc_in = 64'h500;
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    tick;
    checks++;
    if ({out_valid_w, out_valid_n} !== 2'b11) begin
      errors++;
      $display("FAIL held_before_rst got %b%b expected 11", out_valid_w, out_valid_n);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid_w, out_valid_n, cnt_w, cnt_n, rd_n, imm_w, in_ready_w, in_ready_n}
        !== {1'b0, 1'b0, 2'd0, 8'd0, 5'd0, 64'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got ov=%b%b cnt_w=%0d cnt_n=%0d rd=%0d imm=%h rdy=%b%b expected 00 0 0 0 0 11",
               out_valid_w, out_valid_n, cnt_w, cnt_n, rd_n, imm_w, in_ready_w, in_ready_n);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_saturation;
    int exp_w;
    in_valid = 1'b1; inst = 32'h0000_007F;
    for (int i = 0; i < 5; i++) begin
      tick;
      exp_w = (i + 1 > 3) ? 3 : i + 1;
      checks++;
      if ({cnt_w, cnt_n} !== {2'(exp_w), 8'(i + 1)}) begin
        errors++;
        $display("FAIL sat_cnt_%0d got cnt_w=%0d cnt_n=%0d expected %0d %0d", i, cnt_w, cnt_n, exp_w, i + 1);
      end
    end
    in_valid = 1'b0;
    checks++;
    if ({illegal_n, alu_ctrl_n, reg_write_n, mem_read_n, mem_write_n, alu_src_w}
        !== {1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL unknown_opcode got ill=%b alu=%0d rw=%b mr=%b mw=%b src=%b expected 1 15 0 0 0 0",
               illegal_n, alu_ctrl_n, reg_write_n, mem_read_n, mem_write_n, alu_src_w);
    end
    tick;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; inst = '0; pc_in = '0; flush = 1'b0; out_ready = 1'b1;
    test_reset;
    test_addi;
    test_back_to_back;
    test_mext;
    test_imm_formats;
    test_backpressure;
    test_flush;
    test_async_reset;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of imm and pc; legal values 32 and 64.
REQ-002 Parameter M_EXT, default 0, 1 enables RV M-extension decode.
REQ-003 Parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-004 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1; reset is asynchronous and active-high.
REQ-006 Port in_valid/in_ready, input/output, 1 each, upstream handshake.
REQ-007 Port inst, input, 32, instruction word; pc_in, input, XLEN, its address.
REQ-008 Port flush, input, 1, discard the held decoded instruction.
REQ-009 Port out_valid/out_ready, output/input, 1 each, downstream handshake.
REQ-010 Ports rd, rs1, rs2, output, 5 each, register addresses from inst[11:7], [19:15], [24:20].
REQ-011 Ports reg_write, mem_read, mem_write, alu_src, illegal, output, 1 each, registered control flags.
REQ-012 Port alu_ctrl, output, 4, ALU operation code; imm and pc_out, output, XLEN each.
REQ-013 Port illegal_cnt, output, CNT_W, saturating count of accepted illegal instructions.

Function
REQ-014 Opcodes SHALL be lui 0110111, auipc 0010111, jal 1101111, jalr 1100111, branch 1100011, load 0000011, store 0100011, I_op 0010011, R_op 0110011.
REQ-015 alu_ctrl SHALL encode ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, MUL 10, MULH 11, DIV 12, REM 13, PASSB 14.
REQ-016 Mapping: R/I ops by funct3/funct7 to the matching code (slt/slti -> SLT, sltu/sltiu -> SLTU); load, store, jalr, jal, auipc -> ADD; branch -> SUB; lui -> PASSB.
REQ-017 With M_EXT=1, R_op funct7=0000001 SHALL map funct3 000 -> MUL, 001-011 -> MULH, 100-101 -> DIV, 110-111 -> REM.
REQ-018 imm SHALL be sign-extended from bit 31 of inst to XLEN for I/S/B/U/J formats; I-type shifts use zero-extended inst[25:20] when XLEN=64, inst[24:20] when XLEN=32; R-type imm = 0.
REQ-019 reg_write SHALL be 1 for lui, auipc, jal, jalr, load, I_op, R_op; mem_read for load only; mem_write for store only; alu_src for load, store, I_op, jalr.
REQ-020 illegal SHALL be 1 for unknown opcode, unlisted R_op funct7/funct3 combination, funct7=0000001 with M_EXT=0, or shift-immediate with bad upper bits; when illegal, reg_write, mem_read, mem_write SHALL be 0 and alu_ctrl = 15.
REQ-021 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-022 Accept occurs when in_valid && in_ready; decoded fields and pc_out = pc_in SHALL appear registered with out_valid=1 the next cycle (latency 1).
REQ-023 Back-to-back accepts SHALL sustain one instruction per cycle while out_ready=1.
REQ-024 When out_valid=1 and out_ready=0, all outputs SHALL hold stable and in_ready=0.
REQ-025 When out_valid && out_ready and no accept, out_valid SHALL clear next cycle.
REQ-026 flush SHALL clear out_valid next cycle and block any same-cycle accept (in_ready forced 0 while flush=1).
REQ-027 illegal_cnt SHALL increment by 1 per accepted illegal instruction, saturate at 2^CNT_W-1, and not count flushed-away or non-accepted words.

Reset
REQ-028 While rst=1, out_valid=0, illegal_cnt=0, all other outputs 0, in_ready=1 after release; assertion mid-transfer SHALL drop the held instruction immediately.

Verification
REQ-029 inst 0x00500093 (addi x1,x0,5) accepted -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_ctrl=0, alu_src=1, reg_write=1.
REQ-030 inst 0x402081B3 (sub x3,x1,x2) with XLEN=64 -> rd=3, rs1=1, rs2=2, alu_ctrl=1, alu_src=0, imm=0; inst 0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF.
REQ-031 inst 0x022081B3: M_EXT=0 -> illegal=1, reg_write=0, alu_ctrl=15, illegal_cnt 0->1; M_EXT=1 -> alu_ctrl=10, illegal=0.
REQ-032 out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0; release -> next word appears following cycle, no loss or duplication.
REQ-033 flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0, input not accepted; CNT_W=2 with 5 illegal accepts -> illegal_cnt=3.
REQ-034 rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0 and illegal_cnt=0 without waiting for a clock edge.
